// File: rtl/shapool_pkg.sv
// -----------------------------------------------------------------------------
// shapool_pkg
// Definitions shared by the hashing core pool, the nonce tracker and the host
// IO block: pool/nonce size defaults and the nonce tracker state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package shapool_pkg;

  // Defaults reused by the pool and IO blocks.
  localparam int POOL_SIZE_LOG2_DEF = 2;
  localparam int NONCE_WIDTH_DEF    = 32;

  // Nonce tracker state encoding.
  localparam logic [1:0] STATE_IDLE      = 2'b00;
  localparam logic [1:0] STATE_RUN       = 2'b01;
  localparam logic [1:0] STATE_FOUND     = 2'b10;
  localparam logic [1:0] STATE_EXHAUSTED = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = STATE_IDLE,
    RUN       = STATE_RUN,
    FOUND     = STATE_FOUND,
    EXHAUSTED = STATE_EXHAUSTED
  } tracker_state_e;

endpackage : shapool_pkg

// File: rtl/lowest_one_encoder.sv
// -----------------------------------------------------------------------------
// lowest_one_encoder
// Combinational priority encoder: reports the index of the lowest set bit of
// a POOL_SIZE-wide vector, so the lowest-numbered core wins a multi-hit round.
// Ports:
//   bits  in   POOL_SIZE       request vector (per-core hit flags)
//   idx   out  POOL_SIZE_LOG2  index of the lowest set bit (0 when none set)
//   any   out  1               at least one bit set
// -----------------------------------------------------------------------------
module lowest_one_encoder #(
  parameter  int POOL_SIZE_LOG2 = 2,
  localparam int POOL_SIZE      = 2 ** POOL_SIZE_LOG2
) (
  input  logic [POOL_SIZE-1:0]      bits,
  output logic [POOL_SIZE_LOG2-1:0] idx,
  output logic                      any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    idx = '0;
    any = |bits;
    // Scan from the top down so the last match, the lowest set bit, wins.
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = POOL_SIZE_LOG2'(i);
      end
    end
  end

endmodule : lowest_one_encoder

// File: rtl/nonce_tracker.sv
// -----------------------------------------------------------------------------
// nonce_tracker
// Drives the shared per-round nonce to the hashing core pool, detects round
// completion and reports the exact winning 32-bit nonce {core_idx, core_nonce}
// so the host needs no nonce-1 correction and no search over the top bits.
//
// Ports:
//   clk           in   1             core clock
//   reset_n       in   1             synchronous active-low reset
//   start         in   1             pulse: begin search from nonce_base
//   clear         in   1             pulse: return to IDLE from any state
//   nonce_base    in   CTR_WIDTH     first shared nonce, sampled on start
//   round_done    in   1             pulse: cores finished hashing core_nonce
//   core_success  in   POOL_SIZE     per-core hit flags, valid with round_done
//   core_nonce    out  CTR_WIDTH     shared nonce currently hashed
//   busy          out  1             high in RUN
//   result_valid  out  1             high in FOUND
//   result_nonce  out  NONCE_WIDTH   winning nonce, stable while result_valid
//   exhausted     out  1             high in EXHAUSTED
//   rounds        out  CTR_WIDTH+1   accepted rounds since start
//                                    (only with NONCE_TRACKER_ROUND_COUNT_EN)
//
// Optional feature macro: NONCE_TRACKER_ROUND_COUNT_EN adds the rounds counter.
// -----------------------------------------------------------------------------
module nonce_tracker
  import shapool_pkg::*;
#(
  parameter  int POOL_SIZE_LOG2 = POOL_SIZE_LOG2_DEF,
  parameter  int NONCE_WIDTH    = NONCE_WIDTH_DEF,
  localparam int POOL_SIZE      = 2 ** POOL_SIZE_LOG2,
  localparam int CTR_WIDTH      = NONCE_WIDTH - POOL_SIZE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [CTR_WIDTH-1:0]   nonce_base,
  input  logic                   round_done,
  input  logic [POOL_SIZE-1:0]   core_success,
  output logic [CTR_WIDTH-1:0]   core_nonce,
  output logic                   busy,
  output logic                   result_valid,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic                   exhausted
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
  ,
  output logic [CTR_WIDTH:0]     rounds
`endif
);

  tracker_state_e             state_q, state_d;
  logic [CTR_WIDTH-1:0]       core_nonce_q, core_nonce_d;
  logic [NONCE_WIDTH-1:0]     result_nonce_q, result_nonce_d;
  logic                       busy_q, busy_d;
  logic                       result_valid_q, result_valid_d;
  logic                       exhausted_q, exhausted_d;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
  // One bit wider than the counter: a search from 0 to all-ones takes
  // 2**CTR_WIDTH rounds, which still fits.
  logic [CTR_WIDTH:0]         rounds_q, rounds_d;
`endif

  logic [POOL_SIZE_LOG2-1:0]  hit_idx;
  logic                       hit_any;

  lowest_one_encoder #(
    .POOL_SIZE_LOG2 (POOL_SIZE_LOG2)
  ) u_hit_enc (
    .bits (core_success),
    .idx  (hit_idx),
    .any  (hit_any)
  );

  // Next state. Priority: clear > start > round_done (reset handled in the
  // register block and overrides everything).
  always_comb begin
    state_d        = state_q;
    core_nonce_d   = core_nonce_q;
    result_nonce_d = result_nonce_q;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
    rounds_d       = rounds_q;
`endif

    if (clear) begin
      state_d        = IDLE;
      core_nonce_d   = '0;
      result_nonce_d = '0;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
      rounds_d       = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = RUN;
            core_nonce_d = nonce_base;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
            rounds_d     = '0;
`endif
          end
        end

        RUN: begin
          if (round_done) begin
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
            rounds_d = rounds_q + 1'b1;
`endif
            // A hit is checked first so a hit on the all-ones nonce reports
            // FOUND rather than EXHAUSTED. core_nonce is the nonce the cores
            // just hashed, so it is reported unmodified.
            if (hit_any) begin
              state_d        = FOUND;
              result_nonce_d = {hit_idx, core_nonce_q};
            end else if (core_nonce_q == '1) begin
              state_d = EXHAUSTED;
            end else begin
              core_nonce_d = core_nonce_q + 1'b1;
            end
          end
        end

        // FOUND and EXHAUSTED are terminal: everything holds until clear.
        default: ;
      endcase
    end

    // Status flags are decoded from the next state and registered, so they
    // change on the same edge as the state and are mutually exclusive.
    busy_d         = (state_d == RUN);
    result_valid_d = (state_d == FOUND);
    exhausted_d    = (state_d == EXHAUSTED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      core_nonce_q   <= '0;
      result_nonce_q <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      exhausted_q    <= 1'b0;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
      rounds_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      core_nonce_q   <= core_nonce_d;
      result_nonce_q <= result_nonce_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      exhausted_q    <= exhausted_d;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
      rounds_q       <= rounds_d;
`endif
    end
  end

  assign core_nonce   = core_nonce_q;
  assign result_nonce = result_nonce_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign exhausted    = exhausted_q;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
  assign rounds       = rounds_q;
`endif

endmodule : nonce_tracker

// File: tb/tb_nonce_tracker.sv
// -----------------------------------------------------------------------------
// tb_nonce_tracker
// Self-checking bench for nonce_tracker. A driver issues searches (start, a
// sequence of rounds, terminal hold, clear) and pushes the outcome predicted
// by a search-level reference model into a scoreboard queue; a monitor pops
// and compares whenever the DUT raises result_valid or exhausted.
// -----------------------------------------------------------------------------
module tb_nonce_tracker;

  localparam int LOG2 = 2;
  localparam int NW   = 32;
  localparam int CW   = NW - LOG2;
  localparam logic [CW-1:0] ALL1 = '1;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          clear;
  logic [CW-1:0] nonce_base;
  logic          round_done;
  logic [3:0]    core_success;
  logic [CW-1:0] core_nonce;
  logic          busy;
  logic          result_valid;
  logic [NW-1:0] result_nonce;
  logic          exhausted;
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
  logic [CW:0]   rounds;
`endif

  nonce_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .clear        (clear),
    .nonce_base   (nonce_base),
    .round_done   (round_done),
    .core_success (core_success),
    .core_nonce   (core_nonce),
    .busy         (busy),
    .result_valid (result_valid),
    .result_nonce (result_nonce),
    .exhausted    (exhausted)
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
    ,
    .rounds       (rounds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of one search.
  typedef struct {
    bit            found;
    logic [NW-1:0] result;
    logic [CW-1:0] core;
    int            nrounds;
  } exp_t;

  exp_t sb[$];

  // Search-level model: round k hashes base+k; the first round with any hit
  // wins with the lowest hitting core; running past all-ones is exhaustion.
  function automatic exp_t model(input logic [CW-1:0] base, input logic [3:0] hits[$]);
    exp_t e;
    e.found = 0; e.result = '0; e.core = base; e.nrounds = 0;
    for (int k = 0; k < hits.size(); k++) begin
      logic [CW-1:0] n;
      logic [3:0]    iso;
      int            idx;
      n   = base + CW'(k);
      iso = hits[k] & (~hits[k] + 4'd1);
      idx = 0;
      for (int b = 0; b < 4; b++) if (iso[b]) idx = b;
      if (hits[k] != 4'd0) begin
        e.found = 1; e.core = n; e.nrounds = k + 1;
        e.result = (NW'(idx) << CW) | NW'(n);
        return e;
      end else if (n == ALL1) begin
        e.core = n; e.nrounds = k + 1;
        return e;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against the scoreboard on each new terminal indication.
  logic rv_prev = 1'b0;
  logic ex_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && ((result_valid && !rv_prev) || (exhausted && !ex_prev))) begin
      if (sb.size() == 0) begin
        check("unexpected_terminal", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("mon_result_valid", 64'(result_valid), 64'(mon_e.found));
        check("mon_exhausted", 64'(exhausted), 64'(!mon_e.found));
        check("mon_busy", 64'(busy), 64'd0);
        check("mon_result_nonce", 64'(result_nonce), mon_e.found ? 64'(mon_e.result) : 64'd0);
        check("mon_core_nonce", 64'(core_nonce), 64'(mon_e.core));
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
        check("mon_rounds", 64'(rounds), 64'(mon_e.nrounds));
`endif
      end
    end
    rv_prev = result_valid;
    ex_prev = exhausted;
  end

  // One search: start, rounds (with random gaps carrying ignored start pulses
  // and don't-care core_success), terminal hold. Leaves the DUT terminal.
  task automatic run_job(input logic [CW-1:0] base, input logic [3:0] hits[$], input bit gaps);
    exp_t e;
    int   w;
    e = model(base, hits);
    sb.push_back(e);
    nonce_base = base; start = 1'b1;
    tick();
    start = 1'b0; nonce_base = CW'($urandom);
    check("job_busy_after_start", 64'(busy), 64'd1);
    check("job_core_nonce_base", 64'(core_nonce), 64'(base));
    for (int k = 0; k < e.nrounds; k++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          start = 1'($urandom_range(0, 1));
          core_success = 4'($urandom);
          tick();
        end
        start = 1'b0;
      end
      round_done = 1'b1; core_success = hits[k];
      tick();
      round_done = 1'b0; core_success = 4'($urandom);
    end
    w = 0;
    while (sb.size() != 0 && w < 4) begin
      tick();
      w++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    // Terminal state must ignore further rounds and starts.
    for (int j = 0; j < 2; j++) begin
      round_done = 1'b1; start = 1'b1;
      core_success = 4'($urandom); nonce_base = CW'($urandom);
      tick();
    end
    round_done = 1'b0; start = 1'b0;
    check("hold_result_valid", 64'(result_valid), 64'(e.found));
    check("hold_exhausted", 64'(exhausted), 64'(!e.found));
    check("hold_result_nonce", 64'(result_nonce), e.found ? 64'(e.result) : 64'd0);
    check("hold_core_nonce", 64'(core_nonce), 64'(e.core));
  endtask

  task automatic do_clear();
    clear = 1'b1; round_done = 1'(($urandom_range(0, 1)));
    core_success = 4'($urandom);
    tick();
    clear = 1'b0; round_done = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_result_valid", 64'(result_valid), 64'd0);
    check("clr_exhausted", 64'(exhausted), 64'd0);
    check("clr_result_nonce", 64'(result_nonce), 64'd0);
    check("clr_core_nonce", 64'(core_nonce), 64'd0);
`ifdef NONCE_TRACKER_ROUND_COUNT_EN
    check("clr_rounds", 64'(rounds), 64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hq[$];
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; nonce_base = '0;
    round_done = 1'b0; core_success = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_exhausted", 64'(exhausted), 64'd0);
    check("rst_core_nonce", 64'(core_nonce), 64'd0);
    check("rst_result_nonce", 64'(result_nonce), 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic hit: two empty rounds, core 2 hits on the third.
    hq = '{4'b0000, 4'b0000, 4'b0100};
    run_job(30'h10, hq, 1'b0);
    check("basic_result_nonce", 64'(result_nonce), 64'h8000_0012);
    check("basic_core_nonce", 64'(core_nonce), 64'h12);
    check("basic_busy", 64'(busy), 64'd0);
    do_clear();

    // Multiple hits: lowest index (1) wins.
    hq = '{4'b1010};
    run_job(30'h5, hq, 1'b0);
    check("multi_result_nonce", 64'(result_nonce), 64'h4000_0005);
    do_clear();

    // Exhaustion with no wrap.
    hq = '{4'b0000, 4'b0000};
    run_job(30'h3FFF_FFFE, hq, 1'b0);
    check("exh_exhausted", 64'(exhausted), 64'd1);
    check("exh_core_nonce", 64'(core_nonce), 64'h3FFF_FFFF);
    do_clear();

    // Hit on the all-ones nonce beats exhaustion.
    hq = '{4'b0000, 4'b1000};
    run_job(30'h3FFF_FFFE, hq, 1'b0);
    check("ones_result_nonce", 64'(result_nonce), 64'hFFFF_FFFF);
    check("ones_exhausted", 64'(exhausted), 64'd0);
    do_clear();

    // Reset mid-run, coinciding with a hitting round.
    nonce_base = 30'h20; start = 1'b1;
    tick();
    start = 1'b0;
    round_done = 1'b1; core_success = 4'b0000;
    tick();
    reset_n = 1'b0; round_done = 1'b1; core_success = 4'b0001;
    tick();
    reset_n = 1'b1; round_done = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result_valid", 64'(result_valid), 64'd0);
    check("midrst_exhausted", 64'(exhausted), 64'd0);
    check("midrst_core_nonce", 64'(core_nonce), 64'd0);
    check("midrst_result_nonce", 64'(result_nonce), 64'd0);
    // IDLE ignores round_done.
    round_done = 1'b1; core_success = 4'b0001;
    tick();
    round_done = 1'b0;
    check("idle_rd_result_valid", 64'(result_valid), 64'd0);
    check("idle_rd_busy", 64'(busy), 64'd0);

    // Clear and start together in FOUND: clear wins.
    hq = '{4'b0001};
    run_job(30'h100, hq, 1'b0);
    clear = 1'b1; start = 1'b1; nonce_base = 30'h777;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clrstart_busy", 64'(busy), 64'd0);
    check("clrstart_result_valid", 64'(result_valid), 64'd0);
    check("clrstart_core_nonce", 64'(core_nonce), 64'd0);
    nonce_base = 30'h999; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_core_nonce", 64'(core_nonce), 64'h999);
    // start during RUN changes nothing.
    nonce_base = 30'h123; start = 1'b1;
    tick();
    start = 1'b0;
    check("runstart_core_nonce", 64'(core_nonce), 64'h999);
    check("runstart_busy", 64'(busy), 64'd1);
    do_clear();

`ifdef NONCE_TRACKER_ROUND_COUNT_EN
    hq = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    run_job(30'h40, hq, 1'b1);
    check("rounds_five", 64'(rounds), 64'd5);
    do_clear();
`endif

    // Randomized searches.
    for (int j = 0; j < 40; j++) begin
      int            mode;
      int            n;
      logic [CW-1:0] base;
      mode = int'($urandom_range(0, 2));
      hq = {};
      if (mode == 0) begin
        base = CW'($urandom);
        n = int'($urandom_range(1, 6));
        for (int k = 0; k < n - 1; k++) hq.push_back(4'd0);
      end else begin
        base = ALL1 - CW'($urandom_range(0, 4));
        n = 6;
        for (int k = 0; k < n - 1; k++)
          hq.push_back((mode == 2 && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
      hq.push_back(4'($urandom_range(1, 15)));
      run_job(base, hq, 1'b1);
      do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_nonce_tracker
